switch_event_capture: RTL and testbench

Front-end stage for the switch bank that drives the `foo` input interface (I1–I5, I9). It synchronises raw switch levels, debounces each bit with a tick-gated stability counter, and presents a clean level bus. It also offers a valid/ready change-event port that reports which bits flipped since the last accepted event. Downstream logic consumes `sw_out` as levels or `evt_*` as a change stream.

---
 rtl/switch_pkg.sv | 14 +
 rtl/switch_debounce_bit.sv | 65 ++++++
 rtl/switch_event_capture.sv | 92 +++++++++
 tb/tb_switch_event_capture.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// Shared sizing defaults and helpers for the switch capture front end.
package switch_pkg;

    localparam int N_SW_DEFAULT     = 6;
    localparam int DB_TICKS_DEFAULT = 4;

    typedef logic [N_SW_DEFAULT-1:0] sw_vec_t;

    // Counter must hold values 0..ticks, so it needs clog2(ticks+1) bits.
    function automatic int db_cnt_w(input int ticks);
        return $clog2(ticks + 1);
    endfunction

endpackage

// File: rtl/switch_debounce_bit.sv
// One switch lane: 2-flop synchroniser, tick-gated stability counter and
// debounced output flop. flip_o is registered and pulses in the cycle right
// after the output level toggles.
module switch_debounce_bit
    import switch_pkg::*;
#(
    parameter int   DB_TICKS = DB_TICKS_DEFAULT,
    parameter logic RST_VAL  = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    input  logic tick_i,
    output logic level_o,
    output logic flip_o
);

    localparam int CW = db_cnt_w(DB_TICKS);

    logic          s1_q, s2_q;
    logic          lvl_q, lvl_d;
    logic          flip_q, flip_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;

    // Counter clears whenever the synced level agrees with the output, and
    // only advances on tick while they disagree; reaching DB_TICKS toggles.
    always_comb begin
        cnt_inc = cnt_q + CW'(1);
        cnt_d   = cnt_q;
        lvl_d   = lvl_q;
        flip_d  = 1'b0;
        if (s2_q == lvl_q) begin
            cnt_d = '0;
        end else if (tick_i) begin
            if (cnt_inc == CW'(DB_TICKS)) begin
                lvl_d  = ~lvl_q;
                cnt_d  = '0;
                flip_d = 1'b1;
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    // Synchroniser, counter, level and flip registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= RST_VAL;
            s2_q   <= RST_VAL;
            lvl_q  <= RST_VAL;
            cnt_q  <= '0;
            flip_q <= 1'b0;
        end else begin
            s1_q   <= raw_i;
            s2_q   <= s1_q;
            lvl_q  <= lvl_d;
            cnt_q  <= cnt_d;
            flip_q <= flip_d;
        end
    end

    assign level_o = lvl_q;
    assign flip_o  = flip_q;

endmodule

// File: rtl/switch_event_capture.sv
// Debounced switch bank with a valid/ready change-event port. Lanes are
// independent; the top only merges their flips into one event register.
module switch_event_capture
    import switch_pkg::*;
#(
    parameter int              N_SW     = N_SW_DEFAULT,
    parameter int              DB_TICKS = DB_TICKS_DEFAULT,
    parameter logic [N_SW-1:0] RST_VAL  = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_SW-1:0] sw_raw,
    input  logic            tick,
    output logic [N_SW-1:0] sw_out,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [N_SW-1:0] evt_mask,
    output logic [N_SW-1:0] evt_data,
    output logic            ovf,
    input  logic            ovf_clr
);

    logic [N_SW-1:0] level;
    logic [N_SW-1:0] flip;

    for (genvar g = 0; g < N_SW; g++) begin : g_lane
        switch_debounce_bit #(
            .DB_TICKS (DB_TICKS),
            .RST_VAL  (RST_VAL[g])
        ) u_db (
            .clk     (clk),
            .rst_n   (rst_n),
            .raw_i   (sw_raw[g]),
            .tick_i  (tick),
            .level_o (level[g]),
            .flip_o  (flip[g])
        );
    end

    logic            valid_q, valid_d;
    logic [N_SW-1:0] mask_q, mask_d;
    logic [N_SW-1:0] data_q, data_d;
    logic            ovf_q, ovf_d;
    logic            accept;

    // Event merge: a new flip opens an event (or restarts it on accept),
    // otherwise flips OR into the pending mask; re-flipping a pending bit
    // marks overflow. Clear wins over a same-cycle overflow set.
    always_comb begin
        accept  = valid_q && evt_ready;
        valid_d = valid_q;
        mask_d  = mask_q;
        data_d  = data_q;
        ovf_d   = ovf_q;
        if (|flip) begin
            data_d = level;
            if (!valid_q || accept) begin
                valid_d = 1'b1;
                mask_d  = flip;
            end else begin
                mask_d = mask_q | flip;
                if (|(flip & mask_q)) ovf_d = 1'b1;
            end
        end else if (accept) begin
            valid_d = 1'b0;
            mask_d  = '0;
        end
        if (ovf_clr) ovf_d = 1'b0;
    end

    // Event register and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            mask_q  <= '0;
            data_q  <= RST_VAL;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            mask_q  <= mask_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sw_out    = level;
    assign evt_valid = valid_q;
    assign evt_mask  = mask_q;
    assign evt_data  = data_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_switch_event_capture.sv
// Randomised and directed bench for switch_event_capture against a
// cycle-level behavioural model of the debounce/event rules.
module tb_switch_event_capture;
    import switch_pkg::*;

    localparam int N  = 6;
    localparam int DB = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] sw_raw;
    logic         tick;
    logic [N-1:0] sw_out;
    logic         evt_valid;
    logic         evt_ready;
    logic [N-1:0] evt_mask;
    logic [N-1:0] evt_data;
    logic         ovf;
    logic         ovf_clr;

    int checks = 0;
    int errors = 0;

    switch_event_capture #(.N_SW(N), .DB_TICKS(DB), .RST_VAL('0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw_raw    (sw_raw),
        .tick      (tick),
        .sw_out    (sw_out),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_mask  (evt_mask),
        .evt_data  (evt_data),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    // Reference model state
    sw_vec_t m_s1, m_s2, m_out, m_flip, m_mask, m_data;
    logic    m_v, m_ovf;
    int      m_dis[N];   // ticks seen while synced level disagrees with output

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_s1 = '0; m_s2 = '0; m_out = '0; m_flip = '0;
        m_mask = '0; m_data = '0; m_v = 1'b0; m_ovf = 1'b0;
        for (int i = 0; i < N; i++) m_dis[i] = 0;
    endfunction

    function automatic void model_step();
        sw_vec_t nflip, nout;
        logic    acc;
        if (!rst_n) begin
            model_reset();
            return;
        end
        // event port from last cycle's flips
        acc = m_v && evt_ready;
        if (m_flip != 0) begin
            m_data = m_out;
            if (!m_v || acc) begin
                m_v = 1'b1;
                m_mask = m_flip;
            end else begin
                if ((m_flip & m_mask) != 0) m_ovf = 1'b1;
                m_mask = m_mask | m_flip;
            end
        end else if (acc) begin
            m_v = 1'b0;
            m_mask = '0;
        end
        if (ovf_clr) m_ovf = 1'b0;
        // debounce: DB_TICKS ticks of continuous disagreement flip the level
        nflip = '0;
        nout  = m_out;
        for (int i = 0; i < N; i++) begin
            if (m_s2[i] == m_out[i]) m_dis[i] = 0;
            else if (tick) begin
                m_dis[i] = m_dis[i] + 1;
                if (m_dis[i] == DB) begin
                    nout[i] = ~m_out[i];
                    nflip[i] = 1'b1;
                    m_dis[i] = 0;
                end
            end
        end
        m_out = nout;
        m_flip = nflip;
        m_s2 = m_s1;
        m_s1 = sw_raw;
    endfunction

    task automatic cmp_all();
        chk("sw_out", 32'(sw_out), 32'(m_out));
        chk("evt_valid", 32'(evt_valid), 32'(m_v));
        chk("evt_mask", 32'(evt_mask), 32'(m_mask));
        chk("evt_data", 32'(evt_data), 32'(m_data));
        chk("ovf", 32'(ovf), 32'(m_ovf));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        cmp_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        sw_vec_t prev;
        int      n;
        bit      seen;

        // Reset hold with all switches high
        rst_n = 1'b0; sw_raw = 6'h3F; tick = 1'b1; evt_ready = 1'b0; ovf_clr = 1'b0;
        model_reset();
        steps(3);
        chk("rst_sw_out", 32'(sw_out), 32'h0);
        chk("rst_valid", 32'(evt_valid), 32'h0);
        chk("rst_ovf", 32'(ovf), 32'h0);
        rst_n = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            step();
            if (c == 5) chk("c5_sw_out", 32'(sw_out), 32'h0);
            if (c == 6) chk("c6_sw_out", 32'(sw_out), 32'h3F);
            if (c == 6) chk("c6_valid", 32'(evt_valid), 32'h0);
            if (c == 7) chk("c7_valid", 32'(evt_valid), 32'h1);
            if (c == 7) chk("c7_mask", 32'(evt_mask), 32'h3F);
        end

        // Clean restart with switches low
        rst_n = 1'b0; sw_raw = '0;
        steps(2);
        rst_n = 1'b1;
        steps(3);

        // Glitch rejection: 3-cycle pulse ignored, 4-cycle pulse accepted
        evt_ready = 1'b1;
        seen = 1'b0;
        sw_raw[2] = 1'b1; steps(3); sw_raw[2] = 1'b0;
        for (int i = 0; i < 10; i++) begin step(); if (evt_valid) seen = 1'b1; end
        chk("glitch_sw_out", 32'(sw_out), 32'h0);
        chk("glitch_no_evt", 32'(seen), 32'h0);
        seen = 1'b0;
        sw_raw[2] = 1'b1; steps(4); sw_raw[2] = 1'b0;
        for (int i = 0; i < 6; i++) begin step(); if (sw_out[2]) seen = 1'b1; end
        chk("pulse4_flip", 32'(seen), 32'h1);
        steps(8);

        // Tick gating: one tick in four
        sw_raw[0] = 1'b1;
        for (int c = 0; c < 32; c++) begin
            tick = (c % 4 == 3);
            step();
        end
        tick = 1'b1;
        chk("tick_sw0", 32'(sw_out[0]), 32'h1);
        steps(3);

        // Accumulation and overflow with no accepts
        evt_ready = 1'b0;
        sw_raw[1] = 1'b1; steps(9);
        sw_raw[3] = 1'b1; steps(9);
        chk("acc_mask", 32'(evt_mask), 32'h0A);
        chk("acc_ovf0", 32'(ovf), 32'h0);
        sw_raw[1] = 1'b0; steps(9);
        chk("ovf_set", 32'(ovf), 32'h1);
        ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
        chk("ovf_clr", 32'(ovf), 32'h0);
        evt_ready = 1'b1; step(); evt_ready = 1'b0;
        chk("accept_drop", 32'(evt_valid), 32'h0);

        // Accept in the same cycle as a new flip
        sw_raw[0] = 1'b0; steps(9);
        sw_raw[4] = 1'b1;
        n = 0;
        do begin
            prev = m_out;
            step();
            n++;
        end while (prev[4] == m_out[4] && n < 20);
        chk("sim_wait_bound", 32'(n < 20), 32'h1);
        evt_ready = 1'b1; step(); evt_ready = 1'b0;
        chk("sim_valid", 32'(evt_valid), 32'h1);
        chk("sim_mask", 32'(evt_mask), 32'h10);
        chk("sim_ovf", 32'(ovf), 32'h0);

        // Reset with a pending event and a counter part-way
        sw_raw[5] = 1'b1; steps(4);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        cmp_all();
        chk("mid_rst_sw_out", 32'(sw_out), 32'h0);
        chk("mid_rst_valid", 32'(evt_valid), 32'h0);
        chk("mid_rst_mask", 32'(evt_mask), 32'h0);
        sw_raw = '0;
        steps(2);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin step(); if (evt_valid) seen = 1'b1; end
        chk("no_stale_evt", 32'(seen), 32'h0);

        // Randomised traffic against the model
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(7) == 0) begin
                int b;
                b = $urandom_range(N - 1);
                sw_raw[b] = ~sw_raw[b];
            end
            tick      = ($urandom_range(3) != 0);
            evt_ready = ($urandom_range(2) == 0);
            ovf_clr   = ($urandom_range(15) == 0);
            rst_n     = ($urandom_range(599) != 0);
            step();
        end
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
